// File: rtl/riscv_pkg.sv
// Shared load/store definitions: access sizes, responder FSM states and
// small decode helpers used by the data-memory responder.
package riscv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // One bit per byte touched by an access of the given size, at lane 0.
  function automatic logic [7:0] size_mask(input mem_size_t sz);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] off, input mem_size_t sz);
    logic r;
    case (sz)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      SZ_D:    r = |off;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 64-bit memory word and the register file:
// extracts/extends load data and positions store data with its byte enables.
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      offset_i,
  input  mem_size_t       size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] ld_data_o,
  output logic [7:0]      be_o,
  output logic [XLEN-1:0] st_data_o
);

  logic [5:0]      shamt_s;
  logic [XLEN-1:0] lane_s;

  assign shamt_s = {offset_i, 3'b000};
  assign lane_s  = word_i >> shamt_s;

  // Extend the selected lane to full register width
  always_comb begin
    ld_data_o = lane_s;
    case (size_i)
      SZ_B: begin
        if (unsigned_i) ld_data_o = {56'd0, lane_s[7:0]};
        else            ld_data_o = {{56{lane_s[7]}}, lane_s[7:0]};
      end
      SZ_H: begin
        if (unsigned_i) ld_data_o = {48'd0, lane_s[15:0]};
        else            ld_data_o = {{48{lane_s[15]}}, lane_s[15:0]};
      end
      SZ_W: begin
        if (unsigned_i) ld_data_o = {32'd0, lane_s[31:0]};
        else            ld_data_o = {{32{lane_s[31]}}, lane_s[31:0]};
      end
      SZ_D:    ld_data_o = lane_s;
      default: ld_data_o = lane_s;
    endcase
  end

  assign be_o      = size_mask(size_i) << offset_i;
  assign st_data_o = wdata_i << shamt_s;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed
// latency, single-cycle response pulse with extended load data or error.
module data_mem_resp
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  mem_size_t       req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o
);

  localparam int         IDXW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  resp_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, uns_q;
  mem_size_t       size_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            req_ready_q, resp_valid_q, resp_err_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic            accept_s, enter_resp_s, commit_s, err_s, oor_s;
  logic            op_we_s, op_uns_s;
  mem_size_t       op_size_s;
  logic [XLEN-1:0] op_addr_s, op_wdata_s;
  logic [IDXW-1:0] idx_s;
  logic [XLEN-1:0] rd_word_s, ld_data_s, st_data_s, st_mask_s;
  logic [7:0]      be_s;

  assign accept_s     = (state_q == IDLE) && req_valid_i;
  assign enter_resp_s = (state_d == RESP) && (state_q != RESP);

  // With LATENCY=1 the access happens on the accept edge, before the latch holds it
  always_comb begin
    if (state_q == IDLE) begin
      op_we_s    = req_we_i;
      op_addr_s  = req_addr_i;
      op_size_s  = req_size_i;
      op_uns_s   = req_unsigned_i;
      op_wdata_s = req_wdata_i;
    end else begin
      op_we_s    = we_q;
      op_addr_s  = addr_q;
      op_size_s  = size_q;
      op_uns_s   = uns_q;
      op_wdata_s = wdata_q;
    end
  end

  assign oor_s     = (op_addr_s[XLEN-1:3] >= 61'(DEPTH_WORDS));
  assign err_s     = oor_s || is_misaligned(op_addr_s[2:0], op_size_s);
  assign idx_s     = op_addr_s[IDXW+2:3];
  assign rd_word_s = oor_s ? {XLEN{1'b0}} : mem_q[idx_s];
  assign commit_s  = rst_n && enter_resp_s && op_we_s && !err_s;

  mem_lane_align u_align (
    .word_i     (rd_word_s),
    .offset_i   (op_addr_s[2:0]),
    .size_i     (op_size_s),
    .unsigned_i (op_uns_s),
    .wdata_i    (op_wdata_s),
    .ld_data_o  (ld_data_s),
    .be_o       (be_s),
    .st_data_o  (st_data_s)
  );

  // Expand byte enables to a bit mask for the read-modify-write merge
  always_comb begin
    st_mask_s = {XLEN{1'b0}};
    for (int b = 0; b < 8; b++) begin
      st_mask_s[b*8 +: 8] = {8{be_s[b]}};
    end
  end

  // Responder FSM next state and latency countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, handshake and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {XLEN{1'b0}};
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == RESP);
      if (enter_resp_s) begin
        resp_err_q   <= err_s;
        resp_rdata_q <= (err_s || op_we_s) ? {XLEN{1'b0}} : ld_data_s;
      end
    end
  end

  // Request capture on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= {XLEN{1'b0}};
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= {XLEN{1'b0}};
    end else if (accept_s) begin
      we_q    <= req_we_i;
      addr_q  <= req_addr_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Byte-masked store commit; the array is deliberately outside reset
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_q[idx_s] <= (rd_word_s & ~st_mask_s) | (st_data_s & st_mask_s);
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule
